lockstep_checker: RTL and testbench
===================================

# lockstep_checker

Parametrised cycle-by-cycle output comparator for the multi-design comparison benches: it samples the output buses of `NUM_CH` design instances driven from the same stimulus and checks every channel against channel 0, the golden design. It generalises the fixed three-way side-by-side arrangement to any channel count and bus width, and adds the following:

- per-bit compare mask;
- saturating error and cycle counters;
- first-mismatch capture;
- a drainable mismatch log FIFO.

It sits in the bench/FPGA harness next to the instantiated designs.

## Interface
Parameters:
- `NUM_CH`, 3, number of compared channels (≥2); channel 0 is golden
- `WIDTH`, 24, bits per channel (uo_out, uio_out, uio_oe concatenated)
- `CNT_W`, 16, width of the cycle and error counters
- `LOG_DEPTH`, 4, mismatch log FIFO entries (power of two, ≥2)

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `ena` in 1: sample/compare enable
- `clear` in 1: synchronous clear of counters, capture and log
- `ch_data` in NUM_CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH]
- `ch_mask` in WIDTH: 1 = bit is compared
- `mismatch` out 1: registered, 1 if the last sample mismatched on any channel
- `mismatch_ch` out NUM_CH: registered per-channel mismatch flags; bit 0 is always 0
- `cycle_count` out CNT_W: number of samples taken, saturating
- `err_count` out CNT_W: number of mismatching samples, saturating
- `first_valid` out 1: a first mismatch has been captured
- `first_cycle` out CNT_W: sample index of the first mismatch
- `first_ch` out NUM_CH: channel flags of the first mismatch
- `log_valid` out 1: the log FIFO is non-empty (show-ahead)
- `log_ready` in 1: pop request
- `log_cycle` out CNT_W: sample index at the FIFO head
- `log_ch` out NUM_CH: channel flags at the FIFO head
- `log_overflow` out 1: sticky; set when a mismatch was dropped because the log was full

## Operation
- **Sample.** A rising edge with `rst_n`=1, `clear`=0 and `ena`=1 takes a sample, and its sample index is the current `cycle_count`.
- **Channel compare.** For c≥1, channel c mismatches iff ((ch_data[c] ^ ch_data[0]) & ch_mask) != 0.
- **Mismatch flags.**
  - On a sample edge, `mismatch_ch` is loaded with the flag vector and `mismatch` with its OR.
  - On an edge with `ena`=0, both are cleared to 0.
- **cycle_count.** Increments on every sample edge and holds at 2^CNT_W−1.
- **err_count.** Increments on a mismatching sample and saturates at 2^CNT_W−1.
- **First-mismatch capture.** On a mismatching sample with `first_valid`=0:
  - `first_valid` is set to 1;
  - `first_cycle` is loaded with the sample index;
  - `first_ch` is loaded with the flag vector.
  - The capture is then frozen until clear or reset.
- **Log.** Each mismatching sample pushes {index, flags} into the FIFO.
  - When the FIFO is full and no pop occurs on the same edge, the entry is dropped and `log_overflow` is set.
  - When the FIFO is full and a pop occurs on the same edge, the push is accepted.
- **Pop.** A pop happens on an edge where `log_valid`=1 and `log_ready`=1. `log_ready` is ignored while `log_valid`=0.
- **Clear.** `clear`=1 takes priority over `ena`, and any sample on that edge is discarded. Clear zeroes:
  - both counters;
  - the capture and `first_valid`;
  - the FIFO and `log_overflow`;
  - `mismatch` and `mismatch_ch`.
- **Saturated counter.** When `cycle_count` is saturated, the logged and captured indices equal 2^CNT_W−1.

## Timing
- **Reset values.** Synchronous reset (`rst_n`=0 at an edge) sets every output to 0, including `log_valid`, and empties the FIFO. Reset has priority over `clear` and `ena`.
- **Reset mid-run.** Reset asserted mid-operation discards any pending push or pop on that edge.
- **Compare latency.** Data sampled at edge N appears on `mismatch`/`mismatch_ch` after edge N; the counters and capture also update at edge N.
- **Log latency.** An entry pushed at edge N gives `log_valid`=1 after edge N, including from empty. Head data is stable while `log_valid`=1 and no pop occurs.
- **Push plus pop, non-empty.** Count is unchanged; the head advances to the next entry.
- **Push plus pop, empty.** The pop is not possible; the push is accepted.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Identical channels.** Drive identical data on all channels, mask all-ones, `ena`=1 for 10 cycles. Required: `cycle_count`=10, `err_count`=0, `mismatch`=0, `first_valid`=0, `log_valid`=0.
- **Single mismatch, mask on and off.** On sample index 3 flip bit 5 of channel 2.
  - Mask all-ones: one cycle later `mismatch_ch`=3'b100; `first_cycle`=3; `first_ch`=3'b100; `err_count`=1; one log entry {3, 3'b100}.
  - Repeat with mask bit 5 = 0: no mismatch is reported.
- **Log overflow.** Mismatch on channel 1 for 6 consecutive samples (index 0–5), `log_ready`=0, `LOG_DEPTH`=4.
  - Required: `err_count`=6, `log_overflow`=1.
  - Draining yields indices 0, 1, 2, 3, then `log_valid`=0.
- **Full FIFO with same-edge pop.** With the FIFO full, hold `log_ready`=1 on an edge with a mismatching sample at index 9. Required: no overflow, and the last drained entry has index 9.
- **Saturation.** With `CNT_W`=4, continuous mismatches for 20 samples. Required: `cycle_count`=15 and `err_count`=15, held there.
- **Clear and reset.**
  - Assert `clear` together with `ena` and a mismatching input. Required next cycle: all counters 0, `first_valid`=0, `log_valid`=0, `mismatch`=0.
  - Assert `rst_n`=0 during a pop. Required: all outputs 0 one edge later.

Source files
------------

// File: rtl/lockstep_checker.sv
// lockstep_checker: compares NUM_CH output buses cycle by cycle against channel 0,
// with a per-bit mask, saturating counters, first-mismatch capture and a mismatch log.
module lockstep_checker #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      clear,
  input  logic [NUM_CH*WIDTH-1:0]   ch_data,
  input  logic [WIDTH-1:0]          ch_mask,
  output logic                      mismatch,
  output logic [NUM_CH-1:0]         mismatch_ch,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          err_count,
  output logic                      first_valid,
  output logic [CNT_W-1:0]          first_cycle,
  output logic [NUM_CH-1:0]         first_ch,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [CNT_W-1:0]          log_cycle,
  output logic [NUM_CH-1:0]         log_ch,
  output logic                      log_overflow
);

  localparam int unsigned PTR_W  = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef struct packed {
    logic [CNT_W-1:0]  idx;
    logic [NUM_CH-1:0] ch;
  } entry_t;

  logic              r_mismatch;
  logic [NUM_CH-1:0] r_mismatch_ch;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_first_valid;
  logic [CNT_W-1:0]  r_first_cycle;
  logic [NUM_CH-1:0] r_first_ch;
  logic              r_log_valid;
  logic              r_log_overflow;
  logic [FILL_W-1:0] r_fill;
  entry_t            r_q [LOG_DEPTH];

  logic [NUM_CH-1:0] w_flags;
  logic              w_any;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic [PTR_W-1:0]  w_wpos;
  logic [FILL_W-1:0] w_fill_nxt;
  entry_t            w_entry;

  // Masked compare of every channel against the golden channel 0
  always_comb begin
    w_flags = '0;
    for (int c = 1; c < int'(NUM_CH); c++) begin
      w_flags[c] = |((ch_data[c*WIDTH +: WIDTH] ^ ch_data[0 +: WIDTH]) & ch_mask);
    end
  end

  // Log FIFO control: a full log still accepts a push when the head pops on the same edge
  always_comb begin
    w_any      = |w_flags;
    w_full     = (r_fill == FILL_W'(LOG_DEPTH));
    w_pop      = r_log_valid & log_ready;
    w_push_req = ena & w_any;
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
    w_wpos     = w_pop ? PTR_W'(r_fill - FILL_W'(1)) : PTR_W'(r_fill);
    w_fill_nxt = r_fill + FILL_W'(w_push) - FILL_W'(w_pop);
    w_entry.idx = r_cycle_count;
    w_entry.ch  = w_flags;
  end

  // Flags, saturating counters and first-mismatch capture
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_mismatch    <= 1'b0;
      r_mismatch_ch <= '0;
      r_cycle_count <= '0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_cycle <= '0;
      r_first_ch    <= '0;
    end else if (ena) begin
      r_mismatch    <= w_any;
      r_mismatch_ch <= w_flags;
      if (!(&r_cycle_count)) r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_any && !(&r_err_count)) r_err_count <= r_err_count + CNT_W'(1);
      if (w_any && !r_first_valid) begin
        r_first_valid <= 1'b1;
        r_first_cycle <= r_cycle_count;
        r_first_ch    <= w_flags;
      end
    end else begin
      r_mismatch    <= 1'b0;
      r_mismatch_ch <= '0;
    end
  end

  // Shift-style log: entry 0 is always the head, so head outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_fill         <= '0;
      r_log_valid    <= 1'b0;
      r_log_overflow <= 1'b0;
      for (int i = 0; i < int'(LOG_DEPTH); i++) r_q[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < int'(LOG_DEPTH) - 1; i++) r_q[i] <= r_q[i+1];
      end
      if (w_push) r_q[w_wpos] <= w_entry;
      if (w_drop) r_log_overflow <= 1'b1;
      r_fill      <= w_fill_nxt;
      r_log_valid <= (w_fill_nxt != '0);
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_ch  = r_mismatch_ch;
  assign cycle_count  = r_cycle_count;
  assign err_count    = r_err_count;
  assign first_valid  = r_first_valid;
  assign first_cycle  = r_first_cycle;
  assign first_ch     = r_first_ch;
  assign log_valid    = r_log_valid;
  assign log_cycle    = r_q[0].idx;
  assign log_ch       = r_q[0].ch;
  assign log_overflow = r_log_overflow;

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker (3 channels, 24 bits, 4-bit counters, 4-entry log).
module tb_lockstep_checker;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned WIDTH     = 24;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LOG_DEPTH = 4;
  localparam logic [WIDTH-1:0] BASE = 24'h5A3C96;
  localparam logic [WIDTH-1:0] ONES = 24'hFFFFFF;

  logic                    clk = 1'b0;
  logic                    rst_n, ena, clear, log_ready;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [WIDTH-1:0]        ch_mask;
  logic                    mismatch, first_valid, log_valid, log_overflow;
  logic [NUM_CH-1:0]       mismatch_ch, first_ch, log_ch;
  logic [CNT_W-1:0]        cycle_count, err_count, first_cycle, log_cycle;

  int tests = 0;
  int fails = 0;

  lockstep_checker #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CNT_W(CNT_W), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .ch_data(ch_data), .ch_mask(ch_mask),
    .mismatch(mismatch), .mismatch_ch(mismatch_ch), .cycle_count(cycle_count),
    .err_count(err_count), .first_valid(first_valid), .first_cycle(first_cycle),
    .first_ch(first_ch), .log_valid(log_valid), .log_ready(log_ready), .log_cycle(log_cycle),
    .log_ch(log_ch), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                          input logic [WIDTH-1:0] d2);
    ch_data = {d2, d1, d0};
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; clear = 1'b0; log_ready = 1'b0; ch_mask = ONES;
    set_data(BASE, BASE, BASE);
    step();
    check("rst_cycle", 32'(cycle_count), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    check("rst_first_valid", 32'(first_valid), 0);
    check("rst_log_valid", 32'(log_valid), 0);
    check("rst_overflow", 32'(log_overflow), 0);

    // Identical channels for 10 samples
    rst_n = 1'b1; ena = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("ident_cycle", 32'(cycle_count), 10);
    check("ident_err", 32'(err_count), 0);
    check("ident_mismatch", 32'(mismatch), 0);
    check("ident_first_valid", 32'(first_valid), 0);
    check("ident_log_valid", 32'(log_valid), 0);

    // Single mismatch: bit 5 of channel 2 at sample index 3, mask all ones
    do_clear();
    check("clr_cycle", 32'(cycle_count), 0);
    for (int i = 0; i < 6; i++) begin
      set_data(BASE, BASE, (i == 3) ? (BASE ^ 24'h000020) : BASE);
      step();
      if (i == 3) begin
        check("single_mismatch_ch", 32'(mismatch_ch), 32'h4);
        check("single_mismatch", 32'(mismatch), 1);
      end
      if (i == 4) check("single_next_clean", 32'(mismatch_ch), 0);
    end
    check("single_first_valid", 32'(first_valid), 1);
    check("single_first_cycle", 32'(first_cycle), 3);
    check("single_first_ch", 32'(first_ch), 32'h4);
    check("single_err", 32'(err_count), 1);
    check("single_log_valid", 32'(log_valid), 1);
    check("single_log_cycle", 32'(log_cycle), 3);
    check("single_log_ch", 32'(log_ch), 32'h4);
    ena = 1'b0; log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    check("single_popped", 32'(log_valid), 0);
    check("ena0_cycle_hold", 32'(cycle_count), 6);

    // Same stimulus with mask bit 5 cleared: nothing reported
    do_clear();
    ena = 1'b1; ch_mask = ONES & ~24'h000020;
    for (int i = 0; i < 6; i++) begin
      set_data(BASE, BASE, (i == 3) ? (BASE ^ 24'h000020) : BASE);
      step();
      if (i == 3) check("masked_mismatch", 32'(mismatch), 0);
    end
    check("masked_err", 32'(err_count), 0);
    check("masked_first_valid", 32'(first_valid), 0);
    check("masked_log_valid", 32'(log_valid), 0);
    ch_mask = ONES;

    // Overflow: channel 1 mismatches for 6 samples with no pops
    ena = 1'b0; do_clear(); ena = 1'b1;
    set_data(BASE, BASE ^ 24'h000001, BASE);
    for (int i = 0; i < 6; i++) step();
    check("ovf_err", 32'(err_count), 6);
    check("ovf_flag", 32'(log_overflow), 1);
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("ovf_drain_valid", 32'(log_valid), 1);
      check("ovf_drain_cycle", 32'(log_cycle), 32'(k));
      check("ovf_drain_ch", 32'(log_ch), 32'h2);
      log_ready = 1'b1; step(); log_ready = 1'b0;
    end
    check("ovf_drained_empty", 32'(log_valid), 0);
    check("ovf_sticky", 32'(log_overflow), 1);

    // Full log with same-edge pop: indices 5..8 fill it, index 9 pushes while 5 pops
    do_clear(); ena = 1'b1;
    set_data(BASE, BASE, BASE);
    for (int i = 0; i < 5; i++) step();
    set_data(BASE, BASE ^ 24'h800000, BASE);
    for (int i = 0; i < 4; i++) step();
    check("full_head", 32'(log_cycle), 5);
    check("full_no_ovf", 32'(log_overflow), 0);
    log_ready = 1'b1; step(); log_ready = 1'b0; ena = 1'b0;
    check("fullpop_no_ovf", 32'(log_overflow), 0);
    check("fullpop_err", 32'(err_count), 5);
    for (int k = 6; k < 10; k++) begin
      check("fullpop_valid", 32'(log_valid), 1);
      check("fullpop_cycle", 32'(log_cycle), 32'(k));
      log_ready = 1'b1; step(); log_ready = 1'b0;
    end
    check("fullpop_empty", 32'(log_valid), 0);

    // Saturation of 4-bit counters under continuous mismatches
    do_clear(); ena = 1'b1;
    set_data(BASE, BASE ^ 24'h000100, BASE ^ 24'h010000);
    for (int i = 0; i < 20; i++) step();
    check("sat_cycle", 32'(cycle_count), 15);
    check("sat_err", 32'(err_count), 15);
    check("sat_first_cycle", 32'(first_cycle), 0);
    check("sat_first_ch", 32'(first_ch), 32'h6);
    step();
    check("sat_cycle_hold", 32'(cycle_count), 15);
    check("sat_err_hold", 32'(err_count), 15);
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("sat_drain_cycle", 32'(log_cycle), 32'(k));
      log_ready = 1'b1; step(); log_ready = 1'b0;
    end
    check("sat_drained", 32'(log_valid), 0);
    ena = 1'b1; step(); ena = 1'b0;
    check("sat_log_index", 32'(log_cycle), 15);
    check("sat_log_valid", 32'(log_valid), 1);

    // Clear beats a mismatching sample on the same edge
    ena = 1'b1; clear = 1'b1; step(); clear = 1'b0; ena = 1'b0;
    check("clr_cycle0", 32'(cycle_count), 0);
    check("clr_err0", 32'(err_count), 0);
    check("clr_first_valid", 32'(first_valid), 0);
    check("clr_log_valid", 32'(log_valid), 0);
    check("clr_mismatch", 32'(mismatch), 0);
    check("clr_overflow", 32'(log_overflow), 0);

    // Reset during a pop
    ena = 1'b1; step(); step(); ena = 1'b0;
    check("prerst_log_valid", 32'(log_valid), 1);
    log_ready = 1'b1; rst_n = 1'b0; step();
    check("rst_pop_log_valid", 32'(log_valid), 0);
    check("rst_pop_cycle", 32'(cycle_count), 0);
    check("rst_pop_err", 32'(err_count), 0);
    check("rst_pop_first", 32'(first_valid), 0);
    check("rst_pop_log_cycle", 32'(log_cycle), 0);
    rst_n = 1'b1; log_ready = 1'b0; step();
    check("post_rst_log_valid", 32'(log_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
